// File: rtl/seg7_decode_monitor.sv
// seg7_decode_monitor: debounces an active-low 7-segment bus, decodes it back
// to a hex digit and checks that successive accepted digits form an up-count.
module seg7_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [0:6] Seg,
  input  logic       ClrCnt,
  output logic [3:0] Value,
  output logic       Valid,
  output logic       Invalid,
  output logic       Locked,
  output logic       Step,
  output logic       Err,
  output logic [7:0] StepCount,
  output logic [7:0] ErrCount
);

  typedef enum logic {EMPTY, LOCKED} state_t;

  localparam logic [3:0] RUN_TARGET = 4'(STABLE_CYCLES);

  state_t     state_q, state_d;
  logic [0:6] seg_q, seg_d;
  logic [3:0] run_q, run_d;
  logic [3:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       invalid_q, invalid_d;
  logic       step_q, step_d;
  logic       err_q, err_d;
  logic [7:0] stepcnt_q, stepcnt_d;
  logic [7:0] errcnt_q, errcnt_d;

  logic       same;
  logic       accept;
  logic       dec_ok;
  logic [3:0] dec_val;

  // Pattern 1100000 is ambiguous (6 or b); it reads as b only when it
  // directly follows an accepted A.
  function automatic logic [4:0] decode(input logic [6:0] p, input logic after_a);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b1100000: r = after_a ? {1'b1, 4'hB} : {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0001100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Debounce run, decode, sequence check and counter next-state.
  always_comb begin
    state_d   = state_q;
    seg_d     = Seg;
    run_d     = run_q;
    value_d   = value_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    stepcnt_d = stepcnt_q;
    errcnt_d  = errcnt_q;

    // run_q==0 only right after reset: the first sample always opens a run.
    same = (Seg == seg_q) && (run_q != 4'd0);
    if (!same) begin
      run_d = 4'd1;
    end else if (run_q != RUN_TARGET) begin
      run_d = run_q + 4'd1;
    end
    // The run saturates at the target, so acceptance fires once per run.
    accept = (run_d == RUN_TARGET) && (!same || (run_q != RUN_TARGET));

    {dec_ok, dec_val} = decode(Seg, (state_q == LOCKED) && (value_q == 4'hA));

    if (accept) begin
      if (!dec_ok) begin
        invalid_d = 1'b1;
        valid_d   = 1'b0;
        err_d     = 1'b1;
        state_d   = EMPTY;
      end else begin
        value_d   = dec_val;
        valid_d   = 1'b1;
        invalid_d = 1'b0;
        state_d   = LOCKED;
        if (state_q == LOCKED) begin
          if (dec_val == value_q + 4'd1) begin
            step_d = 1'b1;
          end else if ((dec_val != value_q) && (dec_val != 4'h0)) begin
            err_d = 1'b1;
          end
        end
      end
    end

    if (ClrCnt) begin
      stepcnt_d = '0;
      errcnt_d  = '0;
    end else begin
      if (step_d) stepcnt_d = stepcnt_q + 8'd1;
      if (err_d && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= EMPTY;
      seg_q     <= '1;
      run_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      stepcnt_q <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      run_q     <= run_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      step_q    <= step_d;
      err_q     <= err_d;
      stepcnt_q <= stepcnt_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign Value     = value_q;
  assign Valid     = valid_q;
  assign Invalid   = invalid_q;
  assign Locked    = (state_q == LOCKED);
  assign Step      = step_q;
  assign Err       = err_q;
  assign StepCount = stepcnt_q;
  assign ErrCount  = errcnt_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed, table-driven bench for seg7_decode_monitor (STABLE_CYCLES = 4).
module tb_seg7_decode_monitor;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [0:6] Seg = 7'b1111111;
  logic       ClrCnt = 1'b0;
  logic [3:0] Value;
  logic       Valid, Invalid, Locked, Step, Err;
  logic [7:0] StepCount, ErrCount;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned steps_seen, errs_seen;

  seg7_decode_monitor #(.STABLE_CYCLES(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Seg(Seg), .ClrCnt(ClrCnt),
    .Value(Value), .Valid(Valid), .Invalid(Invalid), .Locked(Locked),
    .Step(Step), .Err(Err), .StepCount(StepCount), .ErrCount(ErrCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  seg;
    int unsigned hold;
    logic [3:0]  val;
    logic        vld, inv, lck;
    int unsigned steps, errs;
    logic [7:0]  sc, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a pattern at a falling edge and hold it for n rising edges,
  // counting Step/Err pulses sampled after each rising edge.
  task automatic hold(input logic [6:0] p, input int unsigned n);
    Seg = p;
    steps_seen = 0;
    errs_seen = 0;
    for (int unsigned c = 0; c < n; c++) begin
      @(posedge Clock);
      @(negedge Clock);
      steps_seen += Step;
      errs_seen += Err;
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b1100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic vec_t mk(input logic [6:0] s, input int unsigned h, input logic [3:0] v,
                              input logic vl, input logic iv, input logic lk,
                              input int unsigned st, input int unsigned er,
                              input logic [7:0] sc, input logic [7:0] ec);
    vec_t r;
    r.seg = s; r.hold = h; r.val = v; r.vld = vl; r.inv = iv; r.lck = lk;
    r.steps = st; r.errs = er; r.sc = sc; r.ec = ec;
    return r;
  endfunction

  initial begin
    // Table: pattern, hold, Value, Valid, Invalid, Locked, #Step, #Err, StepCount, ErrCount
    vecs.push_back(mk(7'b0000001, 6, 4'h0, 1, 0, 1, 0, 0, 8'd0, 8'd0));
    vecs.push_back(mk(7'b1001111, 6, 4'h1, 1, 0, 1, 1, 0, 8'd1, 8'd0));
    vecs.push_back(mk(7'b0010010, 6, 4'h2, 1, 0, 1, 1, 0, 8'd2, 8'd0));
    vecs.push_back(mk(7'b0000110, 6, 4'h3, 1, 0, 1, 1, 0, 8'd3, 8'd0));
    vecs.push_back(mk(7'b1001100, 6, 4'h4, 1, 0, 1, 1, 0, 8'd4, 8'd0));
    vecs.push_back(mk(7'b0100100, 6, 4'h5, 1, 0, 1, 1, 0, 8'd5, 8'd0));
    vecs.push_back(mk(7'b1100000, 6, 4'h6, 1, 0, 1, 1, 0, 8'd6, 8'd0));
    vecs.push_back(mk(7'b0001111, 6, 4'h7, 1, 0, 1, 1, 0, 8'd7, 8'd0));
    vecs.push_back(mk(7'b0000000, 6, 4'h8, 1, 0, 1, 1, 0, 8'd8, 8'd0));
    vecs.push_back(mk(7'b0001100, 6, 4'h9, 1, 0, 1, 1, 0, 8'd9, 8'd0));
    vecs.push_back(mk(7'b0001000, 6, 4'hA, 1, 0, 1, 1, 0, 8'd10, 8'd0));
    vecs.push_back(mk(7'b1100000, 6, 4'hB, 1, 0, 1, 1, 0, 8'd11, 8'd0));
    vecs.push_back(mk(7'b0110001, 6, 4'hC, 1, 0, 1, 1, 0, 8'd12, 8'd0));
    vecs.push_back(mk(7'b1000010, 6, 4'hD, 1, 0, 1, 1, 0, 8'd13, 8'd0));
    vecs.push_back(mk(7'b0110000, 6, 4'hE, 1, 0, 1, 1, 0, 8'd14, 8'd0));
    vecs.push_back(mk(7'b0111000, 6, 4'hF, 1, 0, 1, 1, 0, 8'd15, 8'd0));
    vecs.push_back(mk(7'b0000001, 6, 4'h0, 1, 0, 1, 1, 0, 8'd16, 8'd0));
    vecs.push_back(mk(7'b1001111, 6, 4'h1, 1, 0, 1, 1, 0, 8'd17, 8'd0));
    vecs.push_back(mk(7'b0010010, 6, 4'h2, 1, 0, 1, 1, 0, 8'd18, 8'd0));
    vecs.push_back(mk(7'b0000110, 6, 4'h3, 1, 0, 1, 1, 0, 8'd19, 8'd0));
    vecs.push_back(mk(7'b0000000, 3, 4'h3, 1, 0, 1, 0, 0, 8'd19, 8'd0));
    vecs.push_back(mk(7'b0000110, 6, 4'h3, 1, 0, 1, 0, 0, 8'd19, 8'd0));
    vecs.push_back(mk(7'b0100100, 6, 4'h5, 1, 0, 1, 0, 1, 8'd19, 8'd1));
    vecs.push_back(mk(7'b1100000, 6, 4'h6, 1, 0, 1, 1, 0, 8'd20, 8'd1));
    vecs.push_back(mk(7'b0000001, 6, 4'h0, 1, 0, 1, 0, 0, 8'd20, 8'd1));
    vecs.push_back(mk(7'b1111111, 4, 4'h0, 0, 1, 0, 0, 1, 8'd20, 8'd2));
    vecs.push_back(mk(7'b1100000, 6, 4'h6, 1, 0, 1, 0, 0, 8'd20, 8'd2));

    // Reset state
    #7;
    chk("reset_value", 32'(Value), 32'h0);
    chk("reset_flags", 32'({Valid, Invalid, Locked, Step, Err}), 32'h0);
    chk("reset_counts", 32'({StepCount, ErrCount}), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;

    foreach (vecs[i]) begin
      hold(vecs[i].seg, vecs[i].hold);
      chk($sformatf("v%0d_value", i), 32'(Value), 32'(vecs[i].val));
      chk($sformatf("v%0d_flags", i), 32'({Valid, Invalid, Locked}),
          32'({vecs[i].vld, vecs[i].inv, vecs[i].lck}));
      chk($sformatf("v%0d_steps", i), steps_seen, vecs[i].steps);
      chk($sformatf("v%0d_errs", i), errs_seen, vecs[i].errs);
      chk($sformatf("v%0d_stepcnt", i), 32'(StepCount), 32'(vecs[i].sc));
      chk($sformatf("v%0d_errcnt", i), 32'(ErrCount), 32'(vecs[i].ec));
    end

    // Latency and clear-wins-over-increment on the accept edge of a Step (6 -> 7)
    hold(7'b0001111, 3);
    chk("lat_value_before_accept", 32'(Value), 32'h6);
    chk("lat_no_pulse_before", steps_seen + errs_seen, 0);
    chk("clr_stepcnt_before", 32'(StepCount), 32'd20);
    ClrCnt = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ClrCnt = 1'b0;
    chk("clr_step_pulse", 32'(Step), 32'h1);
    chk("clr_stepcnt", 32'(StepCount), 32'h0);
    chk("clr_errcnt", 32'(ErrCount), 32'h0);
    chk("clr_value", 32'(Value), 32'h7);
    @(posedge Clock);
    @(negedge Clock);
    chk("step_one_cycle", 32'(Step), 32'h0);

    // Reset mid-run discards the partial run
    hold(7'b0000000, 2);
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_value", 32'(Value), 32'h0);
    chk("midrst_flags", 32'({Valid, Invalid, Locked, Step, Err}), 32'h0);
    chk("midrst_counts", 32'({StepCount, ErrCount}), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    hold(7'b0000000, 3);
    chk("midrst_not_yet_valid", 32'(Valid), 32'h0);
    hold(7'b0000000, 1);
    chk("midrst_accept_value", 32'(Value), 32'h8);
    chk("midrst_accept_flags", 32'({Valid, Locked}), 32'h3);
    chk("midrst_accept_nopulse", steps_seen + errs_seen, 0);

    // StepCount wraps 255 -> 0 after 256 consecutive steps from 8
    begin
      int unsigned total = 0;
      for (int unsigned i = 1; i <= 256; i++) begin
        hold(seg_of(4'((8 + i) % 16)), 4);
        total += steps_seen;
      end
      chk("wrap_total_steps", total, 256);
      chk("wrap_stepcnt", 32'(StepCount), 32'h0);
      chk("wrap_errcnt", 32'(ErrCount), 32'h0);
      chk("wrap_value", 32'(Value), 32'h8);
    end

    // ErrCount saturates at 255 with 256 invalid accepts
    begin
      int unsigned total = 0;
      for (int unsigned i = 0; i < 256; i++) begin
        hold((i % 2 == 0) ? 7'b1111111 : 7'b1111110, 4);
        total += errs_seen;
      end
      chk("sat_total_errs", total, 256);
      chk("sat_errcnt", 32'(ErrCount), 32'hFF);
      chk("sat_flags", 32'({Valid, Invalid, Locked}), 32'h2);
      chk("sat_value_hold", 32'(Value), 32'h8);
    end

    // Synchronous clear without an accept
    ClrCnt = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ClrCnt = 1'b0;
    chk("sync_clr_errcnt", 32'(ErrCount), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
